// File: rtl/commu_m_pkg.sv
// Shared constants, state encoding and small decode helpers for the commu_m
// frame sequencer (commu_m_ctrl and its byte fetcher).
package commu_m_pkg;

  localparam int FX_AW = 16;

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RREQ  = 3'd3,
    ST_RWAIT = 3'd4,
    ST_RPUSH = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WR) || (b == CMD_RD);
  endfunction

  // A LEN byte of zero stands for a 256-byte frame.
  function automatic logic [8:0] len_decode(input logic [7:0] b);
    return (b == 8'h00) ? 9'd256 : {1'b0, b};
  endfunction

endpackage

// File: rtl/commu_m_if.sv
// Bus bundle between commu_m_ctrl (master) and its environment: SPI rx pop,
// SPI tx push and the fx register bus.
interface commu_m_if;
  import commu_m_pkg::*;

  logic             req_ne;
  logic             req_rd;
  logic [7:0]       req_q;
  logic             rsp_full;
  logic             rsp_wr;
  logic [7:0]       rsp_data;
  logic             fx_wr;
  logic [FX_AW-1:0] fx_waddr;
  logic [7:0]       fx_data;
  logic             fx_rd;
  logic [FX_AW-1:0] fx_raddr;
  logic [7:0]       fx_q;

  modport master (
    input  req_ne, req_q, rsp_full, fx_q,
    output req_rd, rsp_wr, rsp_data, fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr
  );

  modport slave (
    output req_ne, req_q, rsp_full, fx_q,
    input  req_rd, rsp_wr, rsp_data, fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr
  );

endinterface

// File: rtl/commu_m_byte_fetch.sv
// Pops bytes from the SPI rx buffer one at a time and presents each captured
// byte for one cycle on byte_vld/byte_data.
module commu_m_byte_fetch (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       want,
  input  logic       req_ne,
  input  logic [7:0] req_q,
  output logic       req_rd,
  output logic       byte_vld,
  output logic [7:0] byte_data
);

  logic       req_rd_r;
  logic       pend_r;
  logic       byte_vld_r;
  logic [7:0] byte_data_r;

  // Only one byte is in flight at a time, so the consumer's state has already
  // advanced by the time the next pop is decided.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      req_rd_r    <= 1'b0;
      pend_r      <= 1'b0;
      byte_vld_r  <= 1'b0;
      byte_data_r <= 8'h00;
    end else begin
      req_rd_r   <= want && req_ne && !req_rd_r && !pend_r && !byte_vld_r;
      pend_r     <= req_rd_r;
      byte_vld_r <= pend_r;
      if (pend_r) begin
        byte_data_r <= req_q;
      end else begin
        byte_data_r <= byte_data_r;
      end
    end
  end

  assign req_rd    = req_rd_r;
  assign byte_vld  = byte_vld_r;
  assign byte_data = byte_data_r;

endmodule

// File: rtl/commu_m_ctrl.sv
// Frame sequencer: parses W/R frames from SPI rx into fx bus cycles and pushes
// read data to SPI tx. Define COMMU_M_TMO_EN to enable the inter-byte timeout.
module commu_m_ctrl
  import commu_m_pkg::*;
#(
  parameter int RD_LAT  = 2,
  parameter int INT_W   = 16,
  parameter int TMO_CYC = 4096
) (
  input  logic      clk_sys,
  input  logic      rst_n,
  commu_m_if.master bus,
  output logic      arm_int_n,
  output logic      frm_err,
  output logic      busy
);

  localparam int INT_CW = $clog2(INT_W + 1);

  state_t           state_r,    state_nxt;
  logic             is_rd_r,    is_rd_nxt;
  logic [1:0]       hdr_cnt_r,  hdr_cnt_nxt;
  logic [FX_AW-1:0] addr_r,     addr_nxt;
  logic [8:0]       len_r,      len_nxt;
  logic [2:0]       wait_r,     wait_nxt;
  logic [INT_CW-1:0] int_cnt_r, int_cnt_nxt;
  logic             fx_wr_r,    fx_wr_nxt;
  logic [FX_AW-1:0] fx_waddr_r, fx_waddr_nxt;
  logic [7:0]       fx_data_r,  fx_data_nxt;
  logic             fx_rd_r,    fx_rd_nxt;
  logic [FX_AW-1:0] fx_raddr_r, fx_raddr_nxt;
  logic             rsp_wr_r,   rsp_wr_nxt;
  logic [7:0]       rsp_data_r, rsp_data_nxt;
  logic             frm_err_r,  frm_err_nxt;
  logic             busy_r;
  logic             arm_int_n_r;

  logic             want_s;
  logic             byte_vld_s;
  logic [7:0]       byte_data_s;

`ifdef COMMU_M_TMO_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_r, tmo_nxt;
`else
  logic             unused_tmo_s;
  assign unused_tmo_s = |TMO_CYC;
`endif

  assign want_s = (state_r == ST_IDLE) || (state_r == ST_HDR) || (state_r == ST_WDATA);

  commu_m_byte_fetch u_fetch (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .want      (want_s),
    .req_ne    (bus.req_ne),
    .req_q     (bus.req_q),
    .req_rd    (bus.req_rd),
    .byte_vld  (byte_vld_s),
    .byte_data (byte_data_s)
  );

  // Next-state and next-output logic for the frame FSM and interrupt timer.
  always_comb begin
    state_nxt    = state_r;
    is_rd_nxt    = is_rd_r;
    hdr_cnt_nxt  = hdr_cnt_r;
    addr_nxt     = addr_r;
    len_nxt      = len_r;
    wait_nxt     = wait_r;
    fx_wr_nxt    = 1'b0;
    fx_waddr_nxt = fx_waddr_r;
    fx_data_nxt  = fx_data_r;
    fx_rd_nxt    = 1'b0;
    fx_raddr_nxt = fx_raddr_r;
    rsp_wr_nxt   = 1'b0;
    rsp_data_nxt = rsp_data_r;
    frm_err_nxt  = frm_err_r;
    int_cnt_nxt  = (int_cnt_r != '0) ? (int_cnt_r - INT_CW'(1)) : '0;

    case (state_r)
      ST_IDLE: begin
        if (byte_vld_s && is_cmd(byte_data_s)) begin
          frm_err_nxt = 1'b0;
          is_rd_nxt   = (byte_data_s == CMD_RD);
          hdr_cnt_nxt = 2'd0;
          state_nxt   = ST_HDR;
        end else if (byte_vld_s) begin
          frm_err_nxt = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (byte_vld_s) begin
          hdr_cnt_nxt = hdr_cnt_r + 2'd1;
          case (hdr_cnt_r)
            2'd0:    addr_nxt = {byte_data_s, addr_r[7:0]};
            2'd1:    addr_nxt = {addr_r[15:8], byte_data_s};
            default: begin
              len_nxt   = len_decode(byte_data_s);
              state_nxt = is_rd_r ? ST_RREQ : ST_WDATA;
            end
          endcase
        end else begin
          state_nxt = ST_HDR;
        end
      end
      ST_WDATA: begin
        if (byte_vld_s) begin
          fx_wr_nxt    = 1'b1;
          fx_waddr_nxt = addr_r;
          fx_data_nxt  = byte_data_s;
          addr_nxt     = addr_r + 16'd1;
          len_nxt      = len_r - 9'd1;
          state_nxt    = (len_r == 9'd1) ? ST_DONE : ST_WDATA;
        end else begin
          state_nxt = ST_WDATA;
        end
      end
      ST_RREQ: begin
        fx_rd_nxt    = 1'b1;
        fx_raddr_nxt = addr_r;
        wait_nxt     = 3'(RD_LAT);
        state_nxt    = ST_RWAIT;
      end
      ST_RWAIT: begin
        // wait_r reaches zero in the cycle fx_q becomes valid.
        if (wait_r == 3'd0) begin
          rsp_data_nxt = bus.fx_q;
          state_nxt    = ST_RPUSH;
        end else begin
          wait_nxt = wait_r - 3'd1;
        end
      end
      ST_RPUSH: begin
        if (!bus.rsp_full) begin
          rsp_wr_nxt = 1'b1;
          addr_nxt   = addr_r + 16'd1;
          len_nxt    = len_r - 9'd1;
          state_nxt  = (len_r == 9'd1) ? ST_DONE : ST_RREQ;
        end else begin
          state_nxt = ST_RPUSH;
        end
      end
      ST_DONE: begin
        if (is_rd_r) begin
          int_cnt_nxt = INT_CW'(INT_W);
        end else begin
          int_cnt_nxt = int_cnt_nxt;
        end
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

`ifdef COMMU_M_TMO_EN
    tmo_nxt = '0;
    if ((state_r == ST_HDR) || (state_r == ST_WDATA)) begin
      if (byte_vld_s) begin
        tmo_nxt = '0;
      end else if (tmo_r == TMO_W'(TMO_CYC - 1)) begin
        frm_err_nxt = 1'b1;
        int_cnt_nxt = INT_CW'(INT_W);
        state_nxt   = ST_IDLE;
      end else begin
        tmo_nxt = tmo_r + TMO_W'(1);
      end
    end else begin
      tmo_nxt = '0;
    end
`endif
  end

  // State and registered-output update.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      is_rd_r     <= 1'b0;
      hdr_cnt_r   <= 2'd0;
      addr_r      <= 16'h0000;
      len_r       <= 9'd0;
      wait_r      <= 3'd0;
      int_cnt_r   <= '0;
      fx_wr_r     <= 1'b0;
      fx_waddr_r  <= 16'h0000;
      fx_data_r   <= 8'h00;
      fx_rd_r     <= 1'b0;
      fx_raddr_r  <= 16'h0000;
      rsp_wr_r    <= 1'b0;
      rsp_data_r  <= 8'h00;
      frm_err_r   <= 1'b0;
      busy_r      <= 1'b0;
      arm_int_n_r <= 1'b1;
`ifdef COMMU_M_TMO_EN
      tmo_r       <= '0;
`endif
    end else begin
      state_r     <= state_nxt;
      is_rd_r     <= is_rd_nxt;
      hdr_cnt_r   <= hdr_cnt_nxt;
      addr_r      <= addr_nxt;
      len_r       <= len_nxt;
      wait_r      <= wait_nxt;
      int_cnt_r   <= int_cnt_nxt;
      fx_wr_r     <= fx_wr_nxt;
      fx_waddr_r  <= fx_waddr_nxt;
      fx_data_r   <= fx_data_nxt;
      fx_rd_r     <= fx_rd_nxt;
      fx_raddr_r  <= fx_raddr_nxt;
      rsp_wr_r    <= rsp_wr_nxt;
      rsp_data_r  <= rsp_data_nxt;
      frm_err_r   <= frm_err_nxt;
      busy_r      <= (state_nxt != ST_IDLE);
      arm_int_n_r <= (int_cnt_nxt == '0);
`ifdef COMMU_M_TMO_EN
      tmo_r       <= tmo_nxt;
`endif
    end
  end

  assign bus.fx_wr    = fx_wr_r;
  assign bus.fx_waddr = fx_waddr_r;
  assign bus.fx_data  = fx_data_r;
  assign bus.fx_rd    = fx_rd_r;
  assign bus.fx_raddr = fx_raddr_r;
  assign bus.rsp_wr   = rsp_wr_r;
  assign bus.rsp_data = rsp_data_r;
  assign arm_int_n    = arm_int_n_r;
  assign frm_err      = frm_err_r;
  assign busy         = busy_r;

endmodule
